// File: rtl/mux_2to1.sv
// mux_2to1: two-input selector with a combinational output plus
// clock-aligned registered copies of the selected data and of sel.
`default_nettype none

module mux_2to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             sel,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Out_q,
  output logic             sel_q
);

  // Plain ternary so an unknown sel resolves bitwise where I0 and I1 agree.
  assign Out = sel ? I1 : I0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Out_q <= '0;
      sel_q <= 1'b0;
    end else begin
      Out_q <= Out;
      sel_q <= sel;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: table-driven combinational vectors plus directed registered-path sequences.
`default_nettype none

module tb_mux_2to1;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b0;

  logic       i0_1 = 1'b0, i1_1 = 1'b0, sel_1 = 1'b0;
  logic       out_1, out_q_1, sel_q_1;

  logic [7:0] i0_8 = 8'h00, i1_8 = 8'h00;
  logic       sel_8 = 1'b0;
  logic [7:0] out_8, out_q_8;
  logic       sel_q_8;

  int n_checks = 0;
  int n_fail   = 0;

  mux_2to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .I0(i0_1), .I1(i1_1), .sel(sel_1),
    .Out(out_1), .Out_q(out_q_1), .sel_q(sel_q_1)
  );

  mux_2to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .I0(i0_8), .I1(i1_8), .sel(sel_8),
    .Out(out_8), .Out_q(out_q_8), .sel_q(sel_q_8)
  );

  // Clock is gated so the combinational vectors run with clk idle.
  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  typedef struct {
    logic i0;
    logic i1;
    logic sel;
    logic exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Directed sequence followed by exhaustive (I0,I1,sel); expected = sel ? I1 : I0.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 14; i++) begin
      i0_1  = vecs[i].i0;
      i1_1  = vecs[i].i1;
      sel_1 = vecs[i].sel;
      #1;
      check($sformatf("comb_vec%0d", i), {7'd0, out_1}, {7'd0, vecs[i].exp});
    end

    // 8-bit combinational select.
    i0_8 = 8'hA5; i1_8 = 8'h3C; sel_8 = 1'b0;
    #1;
    check("w8_sel0_out", out_8, 8'hA5);
    sel_8 = 1'b1;
    #1;
    check("w8_sel1_out", out_8, 8'h3C);
    sel_8 = 1'b0;
    #1;

    // Reset held for two edges with I1=1, sel=1.
    i0_1 = 1'b0; i1_1 = 1'b1; sel_1 = 1'b1;
    rst_n = 1'b0;
    clk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("rst_hold%0d_out_q", k), {7'd0, out_q_1}, 8'd0);
      check($sformatf("rst_hold%0d_sel_q", k), {7'd0, sel_q_1}, 8'd0);
      check($sformatf("rst_hold%0d_out", k),   {7'd0, out_1},   8'd1);
      check($sformatf("rst_hold%0d_w8_q", k),  out_q_8,         8'h00);
    end

    rst_n = 1'b1;
    tick();
    check("rst_rel_out_q", {7'd0, out_q_1}, 8'd1);
    check("rst_rel_sel_q", {7'd0, sel_q_1}, 8'd1);
    check("w8_rel_out_q",  out_q_8,         8'hA5);

    // 8-bit registered path: one edge after sel change.
    sel_8 = 1'b1;
    #1;
    check("w8_pre_edge_q", out_q_8, 8'hA5);
    tick();
    check("w8_post_edge_q", out_q_8, 8'h3C);
    check("w8_post_edge_sel_q", {7'd0, sel_q_8}, 8'd1);

    // Mid-run reset for a single edge; also changes sel on that edge (reset must win).
    tick();
    check("mid_steady_out_q", {7'd0, out_q_1}, 8'd1);
    rst_n = 1'b0;
    sel_8 = 1'b0;
    tick();
    check("mid_rst_out_q", {7'd0, out_q_1}, 8'd0);
    check("mid_rst_sel_q", {7'd0, sel_q_1}, 8'd0);
    check("mid_rst_out",   {7'd0, out_1},   8'd1);
    check("mid_rst_w8_q",  out_q_8,         8'h00);
    rst_n = 1'b1;
    tick();
    check("mid_rel_out_q", {7'd0, out_q_1}, 8'd1);
    check("mid_rel_w8_q",  out_q_8,         8'hA5);

    // sel toggling every cycle: Out_q lags sel by one edge.
    i0_1 = 1'b0; i1_1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic s;
      logic prev;
      s = (k % 2 == 1);
      prev = sel_q_1;
      sel_1 = s;
      #1;
      check($sformatf("tog%0d_lag_q", k), {7'd0, out_q_1}, {7'd0, prev});
      tick();
      check($sformatf("tog%0d_out_q", k), {7'd0, out_q_1}, {7'd0, s});
      check($sformatf("tog%0d_sel_q", k), {7'd0, sel_q_1}, {7'd0, s});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
